// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Purpose:
//   This is the memory-side responder for the multicycle core's fetch and
//   load/store traffic. It accepts one word request at a time over a
//   valid/ready handshake. It services the request from an internal
//   word-addressed RAM. After WAIT_CYCLES idle cycles it returns a
//   single-cycle response pulse.
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  idle cycles between acceptance and response (0..15)
//
// Configuration macro:
//   MEM_RESPONDER_ERR_EN  When defined, addresses beyond the RAM are flagged
//                         with rsp_err and their writes are dropped. When
//                         undefined, the word index wraps modulo DEPTH_WORDS
//                         and rsp_err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req_valid  in   initiator has a request
//   req_ready  out  responder can accept (decoded from state only)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   32-bit byte address; bits [1:0] are ignored
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  read data (0 for writes and errors), held until the next response
//   rsp_err    out  address out of range, held until the next response
//   dbg_state  out  current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// Handshake:
//   A request transfers on a rising edge where req_valid & req_ready are both 1.
//   req_ready never depends on req_valid. The initiator holds its request
//   stable until that edge. req_valid seen while req_ready is 0 is ignored.
//   rsp_valid is high for exactly one cycle per accepted request. There is
//   no back-pressure on the response.
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;
  logic        in_range;
  logic [AW-1:0] index;
  logic [31:0] mem [DEPTH_WORDS];

  assign index = req_addr[AW+1:2];

`ifdef MEM_RESPONDER_ERR_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];
  assign in_range = (req_addr[31:AW+2] == '0);
`else
  // Upper address bits are dropped so the index wraps modulo DEPTH_WORDS.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign in_range = 1'b1;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign dbg_state = state;

  // State register and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // The response is captured at the accept edge. A read therefore sees
  // every write accepted before it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= ~in_range;
      rsp_rdata <= (req_we || !in_range) ? 32'd0 : mem[index];
    end
  end

  // RAM storage is not reset. The reset gate keeps a request that is held
  // during reset from committing before it is actually accepted.
  always_ff @(posedge clk) begin
    if (reset && accept && req_we && in_range) begin
      mem[index] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Purpose:
//   This is the self-checking bench for mem_responder. It uses two instances.
//   dut2 uses the default WAIT_CYCLES = 2. dut0 uses WAIT_CYCLES = 0.
//   Both instances share the clock and reset.
//
//   Expected values for out-of-range addresses follow MEM_RESPONDER_ERR_EN.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic clk;
  logic reset;

  // dut2 signals (WAIT_CYCLES = 2)
  logic        v2, rdy2, we2, rv2, err2;
  logic [31:0] a2, wd2, rd2;
  logic [1:0]  st2;

  // dut0 signals (WAIT_CYCLES = 0)
  logic        v0, rdy0, we0, rv0, err0;
  logic [31:0] a0, wd0, rd0;
  logic [1:0]  st0;

  int checks = 0;
  int errors = 0;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(v2), .req_ready(rdy2), .req_we(we2), .req_addr(a2), .req_wdata(wd2),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(err2), .dbg_state(st2)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_addr(a0), .req_wdata(wd0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0), .dbg_state(st0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request on dut2. The task is entered at posedge+1 and returns at
  // posedge+1, with the DUT back in IDLE.
  task automatic req2(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err);
    int k;
    v2 = 1'b1; we2 = we; a2 = addr; wd2 = wdata;
    k = 0;
    while (!rdy2 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!rdy2) begin
      errors++;
      $display("FAIL %s: accept timeout", name);
    end
    @(posedge clk); #1;                      // accept edge
    v2 = 1'b0; we2 = $urandom_range(1, 0); a2 = $urandom; wd2 = $urandom;
    k = 0;
    while (!rv2 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check({name, " latency"}, k, 2);
    rdata = rd2;
    err   = err2;
    @(posedge clk); #1;
    check({name, " single pulse"}, {31'd0, rv2}, 32'd0);
    check({name, " ready after"}, {31'd0, rdy2}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];
  bit   oor_err;
  logic [31:0] oor_read0, oor_read104;

  initial begin
    logic [31:0] rd;
    logic        er;
    int          acc_cycles[$];
    int          pulses;
    int          cyc;
    bit          prev_rv;
    bit          will_acc;

`ifdef MEM_RESPONDER_ERR_EN
    oor_err     = 1'b1;
    oor_read0   = 32'h1111_1111;  // out-of-range write was dropped
    oor_read104 = 32'h0;
`else
    oor_err     = 1'b0;
    oor_read0   = 32'h1234_5678;  // 0x100 wraps to index 0
    oor_read104 = 32'h2222_2222;  // 0x104 wraps to index 1
`endif

    vecs[0]  = '{"wr10",   1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0,          1'b0};
    vecs[1]  = '{"rd10",   1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF,  1'b0};
    vecs[2]  = '{"wr10b",  1'b1, 32'h10,  32'h0BAD_F00D, 32'h0,          1'b0};
    vecs[3]  = '{"rd13",   1'b0, 32'h13,  32'h0,         32'h0BAD_F00D,  1'b0};
    vecs[4]  = '{"wr00",   1'b1, 32'h00,  32'h1111_1111, 32'h0,          1'b0};
    vecs[5]  = '{"wr04",   1'b1, 32'h04,  32'h2222_2222, 32'h0,          1'b0};
    vecs[6]  = '{"rd00",   1'b0, 32'h00,  32'h0,         32'h1111_1111,  1'b0};
    vecs[7]  = '{"wr100",  1'b1, 32'h100, 32'h1234_5678, 32'h0,          oor_err};
    vecs[8]  = '{"rd00b",  1'b0, 32'h00,  32'h0,         oor_read0,      1'b0};
    vecs[9]  = '{"wrfc",   1'b1, 32'hFC,  32'hCAFE_F00D, 32'h0,          1'b0};
    vecs[10] = '{"rdfc",   1'b0, 32'hFE,  32'h0,         32'hCAFE_F00D,  1'b0};
    vecs[11] = '{"rd104",  1'b0, 32'h104, 32'h0,         oor_read104,    oor_err};

    // Reset phase. dut0 holds a write so that its acceptance right after
    // reset release can be checked.
    reset = 1'b0;
    v2 = 1'b0; we2 = 1'b0; a2 = '0; wd2 = '0;
    v0 = 1'b1; we0 = 1'b1; a0 = 32'h08; wd0 = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready2",  {31'd0, rdy2}, 32'd1);
    check("reset rvalid2", {31'd0, rv2},  32'd0);
    check("reset rdata2",  rd2,           32'd0);
    check("reset err2",    {31'd0, err2}, 32'd0);
    check("reset state2",  {30'd0, st2},  32'd0);
    check("reset rvalid0", {31'd0, rv0},  32'd0);
    #2 reset = 1'b1;

    // dut0 (WAIT_CYCLES = 0): accept happens at the first edge after release.
    @(posedge clk); #1;
    check("d0 wr rvalid", {31'd0, rv0},  32'd1);
    check("d0 wr ready",  {31'd0, rdy0}, 32'd0);
    check("d0 wr rdata",  rd0,           32'd0);
    v0 = 1'b0;
    @(posedge clk); #1;
    check("d0 idle rvalid", {31'd0, rv0},  32'd0);
    check("d0 idle ready",  {31'd0, rdy0}, 32'd1);
    v0 = 1'b1; we0 = 1'b0; a0 = 32'h08;
    @(posedge clk); #1;
    check("d0 rd rvalid", {31'd0, rv0},  32'd1);
    check("d0 rd ready",  {31'd0, rdy0}, 32'd0);
    check("d0 rd rdata",  rd0,           32'h5555_AAAA);
    v0 = 1'b0;
    @(posedge clk); #1;
    check("d0 rd after", {30'd0, rv0, rdy0}, 32'd1);

    // Table-driven vectors on dut2
    foreach (vecs[i]) begin
      req2(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
      check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, " err"},   {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // Continuous req_valid: 4 reads accepted every 4 cycles, and responses
    // are never seen in two consecutive cycles.
    v2 = 1'b1; we2 = 1'b0; a2 = 32'h10;
    pulses = 0; prev_rv = 1'b0; cyc = 0;
    while (cyc < 40 && (acc_cycles.size() < 4 || pulses < 4)) begin
      will_acc = v2 && rdy2;
      @(posedge clk);
      cyc++;
      if (will_acc) begin
        acc_cycles.push_back(cyc);
        if (acc_cycles.size() == 4) begin
          #1 v2 = 1'b0;
        end else begin
          #1;
        end
      end else begin
        #1;
      end
      if (rv2) begin
        pulses++;
        check("b2b rdata", rd2, 32'h0BAD_F00D);
        if (prev_rv) begin
          errors++;
          $display("FAIL b2b consecutive rsp_valid at cycle %0d", cyc);
        end
      end
      prev_rv = rv2;
    end
    check("b2b accepts", acc_cycles.size(), 4);
    check("b2b pulses",  pulses, 4);
    for (int i = 1; i < acc_cycles.size(); i++)
      check("b2b spacing", acc_cycles[i] - acc_cycles[i-1], 4);
    v2 = 1'b0;
    @(posedge clk); #1;

    // Reset during WAIT after a write: the response is dropped and the write is kept.
    v2 = 1'b1; we2 = 1'b1; a2 = 32'h04; wd2 = 32'hA5A5_A5A5;
    @(posedge clk); #1;       // accepted, now in WAIT
    v2 = 1'b0;
    check("rst state wait", {30'd0, st2}, 32'd1);
    reset = 1'b0;
    #2;
    check("rst ready",  {31'd0, rdy2}, 32'd1);
    check("rst rvalid", {31'd0, rv2},  32'd0);
    #2 reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rv2) pulses++;
    end
    check("rst no rsp", pulses, 0);
    req2("rd04 after rst", 1'b0, 32'h04, 32'h0, rd, er);
    check("rd04 after rst rdata", rd, 32'hA5A5_A5A5);
    check("rd04 after rst err", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle core's load/store and instruction-fetch traffic. It accepts one word request at a time over a valid/ready handshake, services it from an internal word-addressed RAM after a programmable number of wait states, and returns a single-cycle response pulse. It sits between the core's memory address/data path and storage, and provides the responder end of the request the controller raises in its fetch, read and write states.

## Interface
- DEPTH_WORDS, 64: RAM depth in 32-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 2: idle cycles between request acceptance and response; 0..15.

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  initiator has a request
- req_ready  output  1  responder can accept; transfer when req_valid & req_ready at a rising edge
- req_we  input  1  1 = write, 0 = read
- req_addr  input  32  byte address; bits [1:0] ignored
- req_wdata  input  32  write data
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  read data, valid with rsp_valid; 0 for writes
- rsp_err  output  1  address out of range, valid with rsp_valid

## Operation
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]; in range when req_addr[31:log2(DEPTH_WORDS)+2] == 0.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On accept: if WAIT_CYCLES == 0 → RESP, else load wait counter with WAIT_CYCLES−1 → WAIT.
  - WAIT: req_ready = 0; counter decrements each cycle; when counter == 0 → RESP.
  - RESP: req_ready = 0, rsp_valid = 1 for exactly one cycle → IDLE.
- At the accept edge the request is captured. A write commits to RAM at that edge. A read captures RAM[index] into the response register at that edge, so it returns data including all previously accepted writes.
- Out-of-range request: write suppressed, rsp_rdata = 0, rsp_err = 1.
- rsp_rdata and rsp_err hold their values until the next response. Only the rsp_valid cycle is defined.
- req_valid while not ready is ignored. The initiator must hold the request until accepted. Inputs are don't-care outside accept.

## Timing
- Reset (reset = 0): state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1. RAM contents are not reset.
- Accept at edge N → rsp_valid high during cycle N+1+WAIT_CYCLES.
- Next accept possible at the edge ending the RESP cycle. Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- req_ready is a combinational decode of state only. It never depends on req_valid.
- Reset asserted mid-transaction: the pending response is dropped and no rsp_valid is produced. A write already committed at its accept edge remains in RAM.
- Reset released while req_valid = 1: accepted at the first rising edge after release.

## Configuration
- MEM_RESPONDER_ERR_EN defined: range check active as above; out-of-range writes are dropped and rsp_err is reported.
- MEM_RESPONDER_ERR_EN undefined: no range check; the index wraps modulo DEPTH_WORDS, all accesses succeed, and rsp_err is tied to 0.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10, then read 0x10, with WAIT_CYCLES = 2 → write rsp_valid 3 cycles after accept with rsp_rdata = 0; read response rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- WAIT_CYCLES = 0: read accepted at edge N → rsp_valid in cycle N+1, req_ready low only during that cycle.
- req_valid held continuously with 4 reads → accepts exactly every WAIT_CYCLES+2 cycles; rsp_valid pulses one cycle each, never two consecutive cycles.
- With ERR_EN, DEPTH_WORDS = 64: write 0x12345678 to 0x100 → rsp_err = 1; a subsequent read of 0x000 returns its prior value. Without ERR_EN: the same write lands at index 0 and a read of 0x000 returns 0x12345678.
- reset pulsed low during WAIT after a write of 0xA5A5A5A5 to 0x04 → no rsp_valid, req_ready = 1 immediately; a later read of 0x04 returns 0xA5A5A5A5.
- Address 0x13 read after write of 0x0BADF00D to 0x10 → rsp_rdata = 0x0BADF00D (low bits ignored).
